// File: rtl/peridot_pfc_arbiter_if.sv
// Avalon-MM bus bundle for the two-master PFC arbiter.
// The slave modport is the arbiter's view; the master modport is the view
// of whatever drives both Avalon masters and models the PFC core.
interface peridot_pfc_arbiter_if;
    logic [3:0]  avs_a_address;
    logic        avs_a_read;
    logic        avs_a_write;
    logic [31:0] avs_a_writedata;
    logic [31:0] avs_a_readdata;
    logic        avs_a_waitrequest;

    logic [3:0]  avs_b_address;
    logic        avs_b_read;
    logic        avs_b_write;
    logic [31:0] avs_b_writedata;
    logic [31:0] avs_b_readdata;
    logic        avs_b_waitrequest;

    logic [36:0] coe_pfc_cmd;
    logic [31:0] coe_pfc_resp;

    modport slave (
        input  avs_a_address, avs_a_read, avs_a_write, avs_a_writedata,
        output avs_a_readdata, avs_a_waitrequest,
        input  avs_b_address, avs_b_read, avs_b_write, avs_b_writedata,
        output avs_b_readdata, avs_b_waitrequest,
        output coe_pfc_cmd,
        input  coe_pfc_resp
    );

    modport master (
        output avs_a_address, avs_a_read, avs_a_write, avs_a_writedata,
        input  avs_a_readdata, avs_a_waitrequest,
        output avs_b_address, avs_b_read, avs_b_write, avs_b_writedata,
        input  avs_b_readdata, avs_b_waitrequest,
        input  coe_pfc_cmd,
        output coe_pfc_resp
    );
endinterface

// File: rtl/peridot_pfc_arbiter.sv
// Round-robin arbiter sharing one PERIDOT PFC command bus between two
// Avalon-MM masters. One access is in flight at a time; reads wait RD_WAIT
// cycles for the PFC readback to settle before it is captured.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | no access in flight; arbitrate and latch the winner
// S_WRITE  | write strobe on the PFC bus, grantee completes this cycle
// S_RDSET  | read address on the PFC bus, counting settle cycles
// S_RDDONE | readback captured, grantee completes this cycle
module peridot_pfc_arbiter #(
    parameter int unsigned RD_WAIT = 1
) (
    input  logic                         csi_clk,
    input  logic                         rsi_reset,
    output logic                         coe_pfc_clk,
    output logic                         coe_pfc_reset,
    peridot_pfc_arbiter_if.slave         bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WRITE  = 2'd1,
        S_RDSET  = 2'd2,
        S_RDDONE = 2'd3
    } state_t;

    localparam logic [3:0] LP_CNT_INIT = 4'(RD_WAIT - 1);

    state_t      r_state;
    logic        r_gnt_b;
    logic        r_last_b;
    logic [3:0]  r_cnt;
    logic [36:0] r_cmd;
    logic [31:0] r_rd_a;
    logic [31:0] r_rd_b;

    logic        w_req_a;
    logic        w_req_b;
    logic        w_pick_b;
    logic        w_sel_wr;
    logic [3:0]  w_sel_addr;
    logic [31:0] w_sel_data;
    logic        w_done;

    assign w_req_a    = bus.avs_a_read | bus.avs_a_write;
    assign w_req_b    = bus.avs_b_read | bus.avs_b_write;
    // B wins when it is alone, or on a tie when A was served last.
    assign w_pick_b   = w_req_b & (~w_req_a | ~r_last_b);
    // A simultaneous read+write from one master is treated as a write.
    assign w_sel_wr   = w_pick_b ? bus.avs_b_write     : bus.avs_a_write;
    assign w_sel_addr = w_pick_b ? bus.avs_b_address   : bus.avs_a_address;
    assign w_sel_data = w_pick_b ? bus.avs_b_writedata : bus.avs_a_writedata;

    assign w_done     = (r_state == S_WRITE) || (r_state == S_RDDONE);

    // Completion handshake is a pure decode of state and grantee.
    assign bus.avs_a_waitrequest = ~(w_done & ~r_gnt_b);
    assign bus.avs_b_waitrequest = ~(w_done &  r_gnt_b);
    assign bus.avs_a_readdata    = r_rd_a;
    assign bus.avs_b_readdata    = r_rd_b;
    assign bus.coe_pfc_cmd       = r_cmd;
    assign coe_pfc_clk           = csi_clk;
    assign coe_pfc_reset         = rsi_reset;

    // Arbitration, PFC command register, settle counter and readback capture.
    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            r_state  <= S_IDLE;
            r_gnt_b  <= 1'b0;
            r_last_b <= 1'b1;
            r_cnt    <= 4'd0;
            r_cmd    <= 37'd0;
            r_rd_a   <= 32'd0;
            r_rd_b   <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_a || w_req_b) begin
                        r_gnt_b <= w_pick_b;
                        r_cmd   <= {w_sel_wr, w_sel_addr, w_sel_data};
                        r_cnt   <= LP_CNT_INIT;
                        r_state <= w_sel_wr ? S_WRITE : S_RDSET;
                    end
                end
                S_WRITE: begin
                    r_cmd[36] <= 1'b0;
                    r_last_b  <= r_gnt_b;
                    r_state   <= S_IDLE;
                end
                S_RDSET: begin
                    if (r_cnt == 4'd0) begin
                        if (r_gnt_b) begin
                            r_rd_b <= bus.coe_pfc_resp;
                        end else begin
                            r_rd_a <= bus.coe_pfc_resp;
                        end
                        r_state <= S_RDDONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RDDONE: begin
                    r_last_b <= r_gnt_b;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_peridot_pfc_arbiter.sv
// Testbench for peridot_pfc_arbiter: directed scenarios plus randomized
// continuous-request traffic checked against a transaction-level schedule.
module tb_peridot_pfc_arbiter;

    localparam int RD_A = 1;
    localparam int RD_C = 3;
    localparam int MAXC = 96;

    typedef struct {
        logic        wr;
        logic        both;
        logic [3:0]  addr;
        logic [31:0] data;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] xor_a = 32'd0;
    logic [31:0] xor_c = 32'd0;
    logic [31:0] m_hold_a, m_hold_b;
    logic        model_last_b;

    logic pfc_clk_a, pfc_rst_a, pfc_clk_c, pfc_rst_c;

    peridot_pfc_arbiter_if ifa ();
    peridot_pfc_arbiter_if ifc ();

    peridot_pfc_arbiter #(.RD_WAIT(RD_A)) dut_a (
        .csi_clk(clk), .rsi_reset(rst),
        .coe_pfc_clk(pfc_clk_a), .coe_pfc_reset(pfc_rst_a),
        .bus(ifa.slave)
    );

    peridot_pfc_arbiter #(.RD_WAIT(RD_C)) dut_c (
        .csi_clk(clk), .rsi_reset(rst),
        .coe_pfc_clk(pfc_clk_c), .coe_pfc_reset(pfc_rst_c),
        .bus(ifc.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] resp_fn(input logic [3:0] a);
        if (a == 4'hA) return 32'h1234_5678;
        return {4{a, ~a}};
    endfunction

    assign ifa.coe_pfc_resp = resp_fn(ifa.coe_pfc_cmd[35:32]) ^ xor_a;
    assign ifc.coe_pfc_resp = resp_fn(ifc.coe_pfc_cmd[35:32]) ^ xor_c;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifa.avs_a_read = 0; ifa.avs_a_write = 0; ifa.avs_a_address = 0; ifa.avs_a_writedata = 0;
        ifa.avs_b_read = 0; ifa.avs_b_write = 0; ifa.avs_b_address = 0; ifa.avs_b_writedata = 0;
        ifc.avs_a_read = 0; ifc.avs_a_write = 0; ifc.avs_a_address = 0; ifc.avs_a_writedata = 0;
        ifc.avs_b_read = 0; ifc.avs_b_write = 0; ifc.avs_b_address = 0; ifc.avs_b_writedata = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle_inputs();
        xor_a = 0; xor_c = 0;
        m_hold_a = 0; m_hold_b = 0;
        model_last_b = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic drive_a(input bit en, input txn_t t);
        ifa.avs_a_write     = en && t.wr;
        ifa.avs_a_read      = en && (!t.wr || t.both);
        ifa.avs_a_address   = t.addr;
        ifa.avs_a_writedata = t.data;
    endtask

    task automatic drive_b(input bit en, input txn_t t);
        ifa.avs_b_write     = en && t.wr;
        ifa.avs_b_read      = en && (!t.wr || t.both);
        ifa.avs_b_address   = t.addr;
        ifa.avs_b_writedata = t.data;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        n_tests++;
        if (ifa.coe_pfc_cmd !== 37'd0 || ifc.coe_pfc_cmd !== 37'd0) begin
            n_fail++; $display("FAIL reset_cmd: got %h/%h want 0", ifa.coe_pfc_cmd, ifc.coe_pfc_cmd);
        end
        n_tests++;
        if (ifa.avs_a_readdata !== 32'd0 || ifa.avs_b_readdata !== 32'd0 ||
            ifc.avs_a_readdata !== 32'd0 || ifc.avs_b_readdata !== 32'd0) begin
            n_fail++; $display("FAIL reset_readdata: got %h %h want 0", ifa.avs_a_readdata, ifa.avs_b_readdata);
        end
        n_tests++;
        if ({ifa.avs_a_waitrequest, ifa.avs_b_waitrequest, ifc.avs_a_waitrequest, ifc.avs_b_waitrequest} !== 4'b1111) begin
            n_fail++; $display("FAIL reset_waitrequest: got %b%b want 11", ifa.avs_a_waitrequest, ifa.avs_b_waitrequest);
        end
        n_tests++;
        if (pfc_rst_a !== 1'b1 || pfc_clk_a !== clk) begin
            n_fail++; $display("FAIL reset_pfc_passthru: got rst=%b clk=%b want 1/%b", pfc_rst_a, pfc_clk_a, clk);
        end
        rst = 1'b0;
        m_hold_a = 0; m_hold_b = 0; model_last_b = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({ifa.avs_a_waitrequest, ifa.avs_b_waitrequest} !== 2'b11 || ifa.coe_pfc_cmd[36] !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset: got wr=%b%b strobe=%b want 11/0",
                               ifa.avs_a_waitrequest, ifa.avs_b_waitrequest, ifa.coe_pfc_cmd[36]);
        end
    endtask

    task automatic test_single_write();
        ifa.avs_a_address = 4'd5; ifa.avs_a_writedata = 32'hDEADBEEF; ifa.avs_a_write = 1;
        tick();
        n_tests++;
        if (ifa.coe_pfc_cmd !== 37'h1_5DEADBEEF) begin
            n_fail++; $display("FAIL write_cmd: got %h want 15deadbeef", ifa.coe_pfc_cmd);
        end
        n_tests++;
        if (ifa.avs_a_waitrequest !== 1'b0 || ifa.avs_b_waitrequest !== 1'b1) begin
            n_fail++; $display("FAIL write_waitrequest: got a=%b b=%b want 0/1", ifa.avs_a_waitrequest, ifa.avs_b_waitrequest);
        end
        tick();
        ifa.avs_a_write = 0;
        n_tests++;
        if (ifa.coe_pfc_cmd[36] !== 1'b0 || ifa.avs_a_waitrequest !== 1'b1 || ifa.coe_pfc_cmd[35:0] !== 36'h5DEADBEEF) begin
            n_fail++; $display("FAIL write_one_cycle: got cmd=%h wr=%b want 05deadbeef/1", ifa.coe_pfc_cmd, ifa.avs_a_waitrequest);
        end
        tick();
    endtask

    task automatic test_single_read();
        int sbits;
        sbits = 0;
        ifa.avs_b_address = 4'hA; ifa.avs_b_read = 1;
        tick();
        sbits += ifa.coe_pfc_cmd[36];
        n_tests++;
        if (ifa.avs_b_waitrequest !== 1'b1 || ifa.coe_pfc_cmd[35:32] !== 4'hA) begin
            n_fail++; $display("FAIL read_setup: got wr=%b addr=%h want 1/a", ifa.avs_b_waitrequest, ifa.coe_pfc_cmd[35:32]);
        end
        tick();
        sbits += ifa.coe_pfc_cmd[36];
        n_tests++;
        if (ifa.avs_b_waitrequest !== 1'b0 || ifa.avs_b_readdata !== 32'h12345678) begin
            n_fail++; $display("FAIL read_complete: got wr=%b data=%h want 0/12345678", ifa.avs_b_waitrequest, ifa.avs_b_readdata);
        end
        m_hold_b = 32'h12345678;
        tick();
        ifa.avs_b_read = 0;
        sbits += ifa.coe_pfc_cmd[36];
        n_tests++;
        if (sbits != 0 || ifa.avs_b_waitrequest !== 1'b1) begin
            n_fail++; $display("FAIL read_no_strobe: got strobes=%0d wr=%b want 0/1", sbits, ifa.avs_b_waitrequest);
        end
        tick();
    endtask

    task automatic test_simultaneous_writes();
        logic [3:0] seen[$];
        int drops_a, drops_b;
        apply_reset();
        drops_a = 0; drops_b = 0;
        ifa.avs_a_address = 4'd1; ifa.avs_a_writedata = 32'h11; ifa.avs_a_write = 1;
        ifa.avs_b_address = 4'd2; ifa.avs_b_writedata = 32'h22; ifa.avs_b_write = 1;
        for (int c = 0; c < 8; c++) begin
            if (ifa.coe_pfc_cmd[36] === 1'b1) seen.push_back(ifa.coe_pfc_cmd[35:32]);
            if (ifa.avs_a_waitrequest === 1'b0) begin drops_a++; ifa.avs_a_write = 0; end
            if (ifa.avs_b_waitrequest === 1'b0) begin drops_b++; ifa.avs_b_write = 0; end
            tick();
        end
        n_tests++;
        if (seen.size() != 2) begin
            n_fail++; $display("FAIL tie_strobe_count: got %0d want 2", seen.size());
        end else begin
            n_tests++;
            if (seen[0] !== 4'd1 || seen[1] !== 4'd2) begin
                n_fail++; $display("FAIL tie_order: got %h,%h want 1,2", seen[0], seen[1]);
            end
        end
        n_tests++;
        if (drops_a != 1 || drops_b != 1) begin
            n_fail++; $display("FAIL tie_waitrequest_drops: got a=%0d b=%0d want 1/1", drops_a, drops_b);
        end
        model_last_b = 1'b1;
    endtask

    task automatic test_back_to_back();
        int order[$];
        int na, nb, last_c;
        logic [3:0] aa, ab;
        apply_reset();
        na = 0; nb = 0; last_c = -1;
        aa = 4'd0; ab = 4'd8;
        ifa.avs_a_address = aa; ifa.avs_a_read = 1;
        ifa.avs_b_address = ab; ifa.avs_b_read = 1;
        for (int c = 0; c < 60 && (na < 4 || nb < 4); c++) begin
            if (ifa.avs_a_waitrequest === 1'b0 && ifa.avs_a_read) begin
                order.push_back(0); last_c = c;
                n_tests++;
                if (ifa.avs_a_readdata !== resp_fn(aa)) begin
                    n_fail++; $display("FAIL b2b_data_a: got %h want %h", ifa.avs_a_readdata, resp_fn(aa));
                end
                na++; aa = aa + 4'd1; ifa.avs_a_address = aa;
                if (na == 4) ifa.avs_a_read = 0;
            end
            if (ifa.avs_b_waitrequest === 1'b0 && ifa.avs_b_read) begin
                order.push_back(1); last_c = c;
                n_tests++;
                if (ifa.avs_b_readdata !== resp_fn(ab)) begin
                    n_fail++; $display("FAIL b2b_data_b: got %h want %h", ifa.avs_b_readdata, resp_fn(ab));
                end
                nb++; ab = ab + 4'd1; ifa.avs_b_address = ab;
                if (nb == 4) ifa.avs_b_read = 0;
            end
            tick();
        end
        idle_inputs();
        n_tests++;
        if (order.size() != 8) begin
            n_fail++; $display("FAIL b2b_count: got %0d want 8 (timeout)", order.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_tests++;
                if (order[i] != (i % 2)) begin
                    n_fail++; $display("FAIL b2b_order[%0d]: got %0d want %0d", i, order[i], i % 2);
                end
            end
        end
        n_tests++;
        if (last_c != 2 + 7 * (RD_A + 2)) begin
            n_fail++; $display("FAIL b2b_last_cycle: got %0d want %0d", last_c, 2 + 7 * (RD_A + 2));
        end
        m_hold_a = resp_fn(4'd3); m_hold_b = resp_fn(4'd11); model_last_b = 1'b1;
        tick();
    endtask

    task automatic test_rd_wait3();
        logic [31:0] want;
        apply_reset();
        ifc.avs_a_address = 4'd3; ifc.avs_a_read = 1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 2) xor_c = 32'h0F0F_0000;
            if (c == 3) xor_c = 32'h00FF_FF00;
            n_tests++;
            if (ifc.coe_pfc_cmd[36:32] !== 5'h03 || ifc.avs_a_waitrequest !== 1'b1 || ifc.avs_a_readdata !== 32'd0) begin
                n_fail++; $display("FAIL rdwait3_setup[%0d]: got cmd=%h wr=%b data=%h want 03/1/0",
                                   c, ifc.coe_pfc_cmd[36:32], ifc.avs_a_waitrequest, ifc.avs_a_readdata);
            end
        end
        want = resp_fn(4'd3) ^ 32'h00FF_FF00;
        tick();
        n_tests++;
        if (ifc.avs_a_waitrequest !== 1'b0 || ifc.avs_a_readdata !== want) begin
            n_fail++; $display("FAIL rdwait3_complete: got wr=%b data=%h want 0/%h", ifc.avs_a_waitrequest, ifc.avs_a_readdata, want);
        end
        tick();
        ifc.avs_a_read = 0;
        xor_c = 0;
        tick();
    endtask

    task automatic test_reset_midread();
        int b_drops, a_drops;
        b_drops = 0; a_drops = 0;
        ifa.avs_b_address = 4'd7; ifa.avs_b_read = 1;
        tick();
        rst = 1'b1;
        ifa.avs_b_read = 0;
        #1;
        n_tests++;
        if (ifa.coe_pfc_cmd !== 37'd0 || ifa.avs_a_readdata !== 32'd0 || ifa.avs_b_readdata !== 32'd0 ||
            {ifa.avs_a_waitrequest, ifa.avs_b_waitrequest} !== 2'b11) begin
            n_fail++; $display("FAIL midread_reset_outputs: got cmd=%h rd=%h/%h wr=%b%b want 0/0/0/11",
                               ifa.coe_pfc_cmd, ifa.avs_a_readdata, ifa.avs_b_readdata,
                               ifa.avs_a_waitrequest, ifa.avs_b_waitrequest);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            if (ifa.avs_b_waitrequest === 1'b0) b_drops++;
        end
        rst = 1'b0;
        m_hold_a = 0; m_hold_b = 0; model_last_b = 1'b1;
        tick();
        ifa.avs_a_address = 4'hC; ifa.avs_a_writedata = 32'hCAFEF00D; ifa.avs_a_write = 1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (ifa.avs_b_waitrequest === 1'b0) b_drops++;
            if (ifa.avs_a_waitrequest === 1'b0) begin
                a_drops++;
                n_tests++;
                if (ifa.coe_pfc_cmd !== 37'h1_CCAFEF00D || c != 0) begin
                    n_fail++; $display("FAIL post_reset_write: got cmd=%h cycle=%0d want 1ccafef00d/0", ifa.coe_pfc_cmd, c + 1);
                end
                ifa.avs_a_write = 0;
            end
        end
        n_tests++;
        if (b_drops != 0 || a_drops != 1) begin
            n_fail++; $display("FAIL midread_completions: got b=%0d a=%0d want 0/1", b_drops, a_drops);
        end
        model_last_b = 1'b0;
    endtask

    task automatic test_random(input int iters);
        txn_t qa[$], qb[$], cur, blank;
        logic       e_done_a[MAXC], e_done_b[MAXC], e_rd[MAXC];
        int         e_kind[MAXC];
        logic [35:0] e_cmd[MAXC];
        logic [31:0] e_rval[MAXC];
        int na, nb, pa, pb, t, done, end_c, ia, ib;
        logic g_b;
        blank = '{wr: 1'b0, both: 1'b0, addr: 4'd0, data: 32'd0};
        apply_reset();
        for (int it = 0; it < iters; it++) begin
            qa.delete(); qb.delete();
            na = $urandom_range(0, 5); nb = $urandom_range(0, 5);
            if (na + nb == 0) na = 1;
            for (int i = 0; i < na + nb; i++) begin
                cur.wr   = $urandom_range(0, 1);
                cur.both = cur.wr && ($urandom_range(0, 3) == 0);
                cur.addr = 4'($urandom_range(0, 15));
                cur.data = $urandom;
                if (i < na) qa.push_back(cur); else qb.push_back(cur);
            end
            for (int c = 0; c < MAXC; c++) begin
                e_done_a[c] = 0; e_done_b[c] = 0; e_rd[c] = 0; e_kind[c] = 0; e_cmd[c] = 0; e_rval[c] = 0;
            end
            t = 0; pa = 0; pb = 0; end_c = 0;
            while (pa < na || pb < nb) begin
                if (pa < na && pb < nb) g_b = !model_last_b;
                else g_b = (pa >= na);
                if (g_b) begin cur = qb[pb]; pb++; end
                else     begin cur = qa[pa]; pa++; end
                if (cur.wr) begin
                    done = t + 1;
                    e_kind[done] = 1; e_cmd[done] = {cur.addr, cur.data};
                end else begin
                    done = t + RD_A + 1;
                    for (int k = t + 1; k <= done; k++) begin
                        e_kind[k] = 2; e_cmd[k] = {cur.addr, 32'd0};
                    end
                    e_rd[done] = 1; e_rval[done] = resp_fn(cur.addr);
                end
                if (g_b) e_done_b[done] = 1; else e_done_a[done] = 1;
                model_last_b = g_b;
                t = done + 1;
                end_c = t;
            end
            ia = 0; ib = 0;
            drive_a(na > 0, na > 0 ? qa[0] : blank);
            drive_b(nb > 0, nb > 0 ? qb[0] : blank);
            for (int c = 0; c <= end_c + 1; c++) begin
                n_tests++;
                if (ifa.avs_a_waitrequest !== !e_done_a[c] || ifa.avs_b_waitrequest !== !e_done_b[c]) begin
                    n_fail++; $display("FAIL rnd_waitrequest it%0d c%0d: got %b%b want %b%b", it, c,
                                       ifa.avs_a_waitrequest, ifa.avs_b_waitrequest, !e_done_a[c], !e_done_b[c]);
                end
                n_tests++;
                if (ifa.coe_pfc_cmd[36] !== (e_kind[c] == 1)) begin
                    n_fail++; $display("FAIL rnd_strobe it%0d c%0d: got %b want %b", it, c, ifa.coe_pfc_cmd[36], e_kind[c] == 1);
                end
                if (e_kind[c] == 1) begin
                    n_tests++;
                    if (ifa.coe_pfc_cmd[35:0] !== e_cmd[c]) begin
                        n_fail++; $display("FAIL rnd_write_cmd it%0d c%0d: got %h want %h", it, c, ifa.coe_pfc_cmd[35:0], e_cmd[c]);
                    end
                end else if (e_kind[c] == 2) begin
                    n_tests++;
                    if (ifa.coe_pfc_cmd[35:32] !== e_cmd[c][35:32]) begin
                        n_fail++; $display("FAIL rnd_read_addr it%0d c%0d: got %h want %h", it, c, ifa.coe_pfc_cmd[35:32], e_cmd[c][35:32]);
                    end
                end
                if (e_rd[c] && e_done_a[c]) m_hold_a = e_rval[c];
                if (e_rd[c] && e_done_b[c]) m_hold_b = e_rval[c];
                n_tests++;
                if (ifa.avs_a_readdata !== m_hold_a || ifa.avs_b_readdata !== m_hold_b) begin
                    n_fail++; $display("FAIL rnd_readdata it%0d c%0d: got %h/%h want %h/%h", it, c,
                                       ifa.avs_a_readdata, ifa.avs_b_readdata, m_hold_a, m_hold_b);
                end
                if (ifa.avs_a_waitrequest === 1'b0 && (ifa.avs_a_read || ifa.avs_a_write) && ia < na) begin
                    ia++;
                    drive_a(ia < na, ia < na ? qa[ia] : blank);
                end
                if (ifa.avs_b_waitrequest === 1'b0 && (ifa.avs_b_read || ifa.avs_b_write) && ib < nb) begin
                    ib++;
                    drive_b(ib < nb, ib < nb ? qb[ib] : blank);
                end
                tick();
            end
            idle_inputs();
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        m_hold_a = 0; m_hold_b = 0; model_last_b = 1'b1;
        tick();
        test_reset();
        test_single_write();
        test_single_read();
        test_simultaneous_writes();
        test_back_to_back();
        test_rd_wait3();
        test_reset_midread();
        test_random(25);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
